// File: rtl/ddc_frame_rx.sv
// ddc_frame_rx: receive end of the {I,Q} AXI-stream sample link. Checks tlast framing and captures
// CAP_FRAMES whole frames into a RAM read back over the lbs bus. Optional feature macro: DDC_RX_SAT_CNT_EN.
module ddc_frame_rx #(
    parameter int          FRAME_LEN  = 256,
    parameter int          CAP_FRAMES = 8,
    parameter logic [13:0] BUF_BASE   = 14'd0,
    parameter logic [13:0] CMD_ADDR   = 14'd16000,
    parameter logic [13:0] STAT_ADDR  = 14'd16001
) (
    input  logic        axis_clk,
    input  logic        rst,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [31:0] s_tdata,
    input  logic        s_tlast,
    input  logic        lbs_we,
    input  logic [13:0] lbs_addr,
    input  logic [31:0] lbs_din,
    output logic [31:0] lbs_dout,
    output logic        cap_done,
    output logic        frame_err
);

    localparam int DEPTH = FRAME_LEN * CAP_FRAMES;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [31:0] CMD_ARM   = 32'h0000_5555;
    localparam logic [31:0] CMD_TRIG  = 32'h0000_FFFF;
    localparam logic [31:0] CMD_ABORT = 32'h0000_8888;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_SYNC    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_tready;
    logic [BW-1:0]   r_beat_cnt;
    logic [12:0]     r_wr_ptr;
    logic [7:0]      r_err_cnt;
    logic            r_ferr;
    logic            r_ferr_seen;
    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_ram_q;
    logic [31:0]     r_reg_q;
    logic            r_sel_ram;

    logic            w_beat;
    logic            w_last_pos;
    logic            w_ferr;
    logic            w_cmd;
    logic            w_arm;
    logic            w_trig;
    logic            w_abort;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic [14:0]     w_rd_off;
    logic            w_in_buf;
    logic [31:0]     w_status;
    logic [31:0]     w_reg_rd;

    assign s_tready  = r_tready;
    assign frame_err = r_ferr;

    assign w_beat     = s_tvalid & r_tready;
    assign w_last_pos = (r_beat_cnt == BW'(FRAME_LEN - 1));
    assign w_ferr     = w_beat & (s_tlast ^ w_last_pos);

    assign w_cmd   = lbs_we & (lbs_addr == CMD_ADDR);
    assign w_arm   = w_cmd & (lbs_din == CMD_ARM);
    assign w_trig  = w_cmd & (lbs_din == CMD_TRIG);
    assign w_abort = w_cmd & (lbs_din == CMD_ABORT);

    // Stream is always drained; beat_cnt realigns on every tlast and wraps at the frame length.
    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            r_tready   <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_tready <= 1'b1;
            if (w_beat) begin
                r_beat_cnt <= (s_tlast | w_last_pos) ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            r_ferr      <= 1'b0;
            r_err_cnt   <= '0;
            r_ferr_seen <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            if (w_arm) begin
                r_err_cnt   <= '0;
                r_ferr_seen <= 1'b0;
            end else if (w_ferr) begin
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
                r_ferr_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ABORT outranks ARM, ARM outranks anything the stream does in the same cycle.
    always_comb begin
        w_next_state = r_state;
        if (w_abort) begin
            w_next_state = ST_IDLE;
        end else if (w_arm) begin
            w_next_state = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED:   if (w_trig) w_next_state = ST_SYNC;
                ST_SYNC:    if (w_beat && r_beat_cnt == '0) w_next_state = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (w_ferr) begin
                        w_next_state = ST_IDLE;
                    end else if (w_beat && r_wr_ptr == 13'(DEPTH - 1)) begin
                        w_next_state = ST_DONE;
                    end
                end
                default:    w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned (no latch).
        w_wr_en   = 1'b0;
        w_wr_addr = (r_state == ST_SYNC) ? '0 : r_wr_ptr[AW-1:0];
        cap_done  = (r_state == ST_DONE);
        if (!w_abort && !w_arm) begin
            case (r_state)
                ST_SYNC:    w_wr_en = w_beat && (r_beat_cnt == '0);
                ST_CAPTURE: w_wr_en = w_beat && !w_ferr;
                default:    w_wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_abort || w_arm) begin
            r_wr_ptr <= '0;
        end else if (w_wr_en) begin
            r_wr_ptr <= 13'(w_wr_addr) + 13'd1;
        end
    end

`ifdef DDC_RX_SAT_CNT_EN
    logic [15:0] r_sat_cnt;
    logic        w_sat_hit;

    assign w_sat_hit = (s_tdata[31:16] == 16'h7FFF) || (s_tdata[31:16] == 16'h8000) ||
                       (s_tdata[15:0]  == 16'h7FFF) || (s_tdata[15:0]  == 16'h8000);

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            r_sat_cnt <= '0;
        end else if (w_arm) begin
            r_sat_cnt <= '0;
        end else if (w_wr_en && w_sat_hit && r_sat_cnt != 16'hFFFF) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end
`endif

    // NOTE: the capture RAM has no reset so it maps onto block RAM; only its control path is reset.
    always_ff @(posedge axis_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= s_tdata;
        end
        r_ram_q <= r_mem[w_rd_off[AW-1:0]];
    end

    // Addresses below BUF_BASE wrap to a large offset and fall outside the buffer window.
    assign w_rd_off = {1'b0, lbs_addr} - {1'b0, BUF_BASE};
    assign w_in_buf = (w_rd_off < 15'(DEPTH));

    always_comb begin
        w_status = {r_wr_ptr, 3'b000, r_err_cnt, 4'b0000, r_ferr_seen, r_state};
        w_reg_rd = '0;
        if (lbs_addr == STAT_ADDR) begin
            w_reg_rd = w_status;
        end
`ifdef DDC_RX_SAT_CNT_EN
        else if (lbs_addr == STAT_ADDR + 14'd1) begin
            w_reg_rd = {16'h0000, r_sat_cnt};
        end
`endif
    end

    always_ff @(posedge axis_clk or posedge rst) begin
        if (rst) begin
            r_sel_ram <= 1'b0;
            r_reg_q   <= '0;
        end else begin
            r_sel_ram <= w_in_buf;
            r_reg_q   <= w_reg_rd;
        end
    end

    assign lbs_dout = r_sel_ram ? r_ram_q : r_reg_q;

endmodule
